multicycle_ctrl: RTL and testbench

- Multicycle control FSM that sequences the instruction decoder, ALU, register file, PC and the shared instruction/data memory port.
- Each instruction steps through fetch, decode, execute, optional memory access and writeback.
- Consumes the decoder outputs (instrType, op, rd, writeLen) and produces all datapath enables and selects.
- Detects illegal instructions, illegal access widths and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory request port between the control FSM and memory.
interface multicycle_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic [2:0] mem_len;
  logic       mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, mem_len, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, mem_len, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing, datapath
// enables and selects, illegal-instruction/width/timeout trapping, retire counter.
package multicycle_ctrl_pkg;
  typedef enum logic [2:0] {
    INS_R, INS_I, INS_S, INS_B, INS_U, INS_J, INS_INVALID
  } instype_t;
endpackage

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  instype_t          instrType,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [2:0]        writeLen,
  input  logic              branch_taken,
  multicycle_ctrl_if.master mem,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic              alu_a_pc,
  output logic              alu_b_imm,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [31:0]       instret,
  output logic              busy
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state_q, state_d;
  instype_t   cls_q;
  logic [6:0] op_q;
  logic [4:0] rd_q;
  logic [2:0] len_q;
  logic       bt_q;
  logic [7:0] tmo_q;
  logic       trap_q;
  logic [1:0] cause_q, cause_d;
  logic [31:0] instret_q;

  logic req, we, addr_sel;
  logic [2:0] len;

  // class of the latched instruction
  logic is_load, is_store, is_jal, is_jalr, use_imm, use_pc, writes_rd;
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (cls_q == INS_S);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);
  assign use_imm   = (cls_q == INS_I) || (cls_q == INS_S) || (cls_q == INS_U) || (cls_q == INS_J);
  assign use_pc    = (op_q == OP_AUIPC) || (cls_q == INS_B) || (cls_q == INS_J);
  assign writes_rd = ((cls_q == INS_R) || (cls_q == INS_I) || (cls_q == INS_U) ||
                      (cls_q == INS_J) || is_load) && (rd_q != 5'd0);

  // decode-cycle checks use the live decoder outputs
  logic dec_mem, dec_len_ok, tmo_hit;
  assign dec_mem    = (op == OP_LOAD) || (instrType == INS_S);
  assign dec_len_ok = (writeLen == 3'd1) || (writeLen == 3'd2) || (writeLen == 3'd4);
  assign tmo_hit    = !mem.mem_ready && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d == S_TRAP) trap_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cls_q     <= INS_R;
      op_q      <= '0;
      rd_q      <= '0;
      len_q     <= '0;
      bt_q      <= 1'b0;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      if (state_q == S_DECODE) begin
        cls_q <= instrType;
        op_q  <= op;
        rd_q  <= rd;
        len_q <= writeLen;
      end
      if (state_q == S_EXEC) bt_q <= branch_taken;
      // counter sits at zero outside the request states, so every entry starts clean
      if (state_q != S_FETCH && state_q != S_MEM) tmo_q <= '0;
      else if (!mem.mem_ready)                    tmo_q <= tmo_q + 8'd1;
      if (state_q == S_WB) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    req       = 1'b0;
    we        = 1'b0;
    addr_sel  = 1'b0;
    len       = 3'd0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        req   = 1'b1;
        len   = 3'd4;
        ir_we = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
        else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_DECODE: begin
        if (instrType == INS_INVALID) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else if (dec_mem && !dec_len_ok) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_a_pc  = use_pc;
        alu_b_imm = use_imm;
        state_d   = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // operand selects held so the ALU address stays stable across wait states
        alu_a_pc  = use_pc;
        alu_b_imm = use_imm;
        req       = 1'b1;
        we        = is_store;
        addr_sel  = 1'b1;
        len       = len_q;
        if (mem.mem_ready) state_d = S_WB;
        else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB: begin
        alu_a_pc  = use_pc;
        alu_b_imm = use_imm;
        pc_we     = 1'b1;
        if (is_jal || (cls_q == INS_B && bt_q)) pc_sel = 2'd1;
        else if (is_jalr)                       pc_sel = 2'd2;
        rf_we     = writes_rd;
        if (is_load)                 wb_sel = 2'd1;
        else if (is_jal || is_jalr)  wb_sel = 2'd2;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;
  assign mem.mem_len      = len;
  assign trap             = trap_q;
  assign trap_cause       = cause_q;
  assign instret          = instret_q;
  assign busy             = (state_q != S_IDLE) && (state_q != S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream against a per-instruction cycle-script model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TMO = 16;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic clk = 1'b0;
  logic rstn, run, branch_taken;
  instype_t instrType;
  logic [6:0] op;
  logic [4:0] rd;
  logic [2:0] writeLen;
  logic ir_we, pc_we, rf_we, alu_a_pc, alu_b_imm, trap, busy;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .run(run), .instrType(instrType), .op(op), .rd(rd),
    .writeLen(writeLen), .branch_taken(branch_taken), .mem(mif),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .trap(trap), .trap_cause(trap_cause),
    .instret(instret), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, mem_we, mem_addr_sel;
    logic [2:0] mem_len;
    logic ir_we, pc_we;
    logic [1:0] pc_sel;
    logic rf_we;
    logic [1:0] wb_sel;
    logic alu_a_pc, alu_b_imm, trap;
    logic [1:0] trap_cause;
    logic [31:0] instret;
    logic busy;
  } obs_t;

  obs_t act;
  assign act = {mif.mem_req, mif.mem_we, mif.mem_addr_sel, mif.mem_len, ir_we, pc_we,
                pc_sel, rf_we, wb_sel, alu_a_pc, alu_b_imm, trap, trap_cause, instret, busy};

  obs_t  exp_o;
  bit    exp_v = 0;
  string exp_tag = "";
  int    checks = 0, errors = 0;
  logic [31:0] m_instret = '0;
  logic        m_trap = 0;
  logic [1:0]  m_cause = '0;
  obs_t        last_wb;
  bit          st_we_seen = 0;

  always @(negedge clk) begin
    if (exp_v) begin
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL %s @%0t: got %h want %h", exp_tag, $time, act, exp_o);
      end
    end
    if (mif.mem_req && mif.mem_we) st_we_seen = 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic obs_t base();
    obs_t o = '0;
    o.instret = m_instret;
    o.trap = m_trap;
    o.trap_cause = m_cause;
    return o;
  endfunction

  task automatic junk();
    instrType    = instype_t'($urandom_range(0, 6));
    op           = 7'($urandom);
    rd           = 5'($urandom);
    writeLen     = 3'($urandom);
    branch_taken = 1'($urandom);
  endtask

  task automatic cyc(input obs_t e, input string tag);
    exp_o = e; exp_tag = tag; exp_v = 1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    exp_v = 0; rstn = 0; run = 0; mif.mem_ready = 0; junk();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(act), 64'd0);
    rstn = 1;
    m_instret = '0; m_trap = 0; m_cause = '0;
  endtask

  task automatic go_idle(input int n);
    obs_t e;
    for (int i = 0; i <= n; i++) begin
      junk(); mif.mem_ready = 1'($urandom);
      run = (i == n);
      e = base();
      cyc(e, "idle");
    end
  endtask

  task automatic trap_cycles(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      junk(); run = 1'($urandom); mif.mem_ready = 1'($urandom);
      e = base();
      cyc(e, "trap");
    end
  endtask

  // Expected cycle script for one instruction; DUT must be in FETCH on entry.
  task automatic do_instr(input instype_t c, input logic [6:0] o, input logic [4:0] r,
                          input logic [2:0] wl, input logic bt, input int fw, input int mw,
                          input logic run_after, input bit abort_mem, output int lat);
    obs_t e;
    bit ld, st, imm, apc;
    lat = 0;
    for (int i = 0; ; i++) begin
      junk(); run = 1'($urandom); mif.mem_ready = (i == fw);
      e = base(); e.busy = 1; e.mem_req = 1; e.mem_len = 3'd4; e.ir_we = (i == fw);
      cyc(e, "fetch"); lat++;
      if (i == fw) break;
      if (i + 1 == TMO) begin m_trap = 1; m_cause = 2'b11; return; end
    end
    junk(); run = 1'($urandom); mif.mem_ready = 1'($urandom);
    instrType = c; op = o; rd = r; writeLen = wl;
    e = base(); e.busy = 1;
    cyc(e, "decode"); lat++;
    ld = (o == OP_LOAD);
    st = (c == INS_S);
    if (c == INS_INVALID) begin m_trap = 1; m_cause = 2'b01; return; end
    if ((ld || st) && !(wl inside {3'd1, 3'd2, 3'd4})) begin m_trap = 1; m_cause = 2'b10; return; end
    imm = c inside {INS_I, INS_S, INS_U, INS_J};
    apc = (o == OP_AUIPC) || (c == INS_B) || (c == INS_J);
    junk(); run = 1'($urandom); mif.mem_ready = 1'($urandom); branch_taken = bt;
    e = base(); e.busy = 1; e.alu_a_pc = apc; e.alu_b_imm = imm;
    cyc(e, "exec"); lat++;
    if (ld || st) begin
      for (int i = 0; ; i++) begin
        junk(); run = 1'($urandom); mif.mem_ready = (i == mw);
        e = base(); e.busy = 1; e.alu_a_pc = apc; e.alu_b_imm = imm;
        e.mem_req = 1; e.mem_we = st; e.mem_addr_sel = 1; e.mem_len = wl;
        if (abort_mem && i == 2) begin
          exp_o = e; exp_tag = "mem_pre_abort"; exp_v = 1;
          #5;
          exp_v = 0; rstn = 0;
          #1;
          chk("abort_mem_req", 64'(mif.mem_req), 64'd0);
          return;
        end
        cyc(e, "mem"); lat++;
        if (i == mw) break;
        if (i + 1 == TMO) begin m_trap = 1; m_cause = 2'b11; return; end
      end
    end
    junk(); run = run_after; mif.mem_ready = 1'($urandom);
    e = base(); e.busy = 1; e.alu_a_pc = apc; e.alu_b_imm = imm; e.pc_we = 1;
    e.pc_sel = (o == OP_JAL || (c == INS_B && bt)) ? 2'd1 : (o == OP_JALR) ? 2'd2 : 2'd0;
    e.rf_we  = ((c inside {INS_R, INS_I, INS_U, INS_J}) || ld) && (r != 5'd0);
    e.wb_sel = ld ? 2'd1 : (o == OP_JAL || o == OP_JALR) ? 2'd2 : 2'd0;
    last_wb = e;
    cyc(e, "wb"); lat++;
    m_instret++;
  endtask

  task automatic pick(output instype_t c, output logic [6:0] o, output logic [2:0] wl);
    int unsigned k = $urandom_range(0, 8);
    wl = 3'($urandom);
    case (k)
      0: begin c = INS_R; o = 7'b0110011; end
      1: begin c = INS_I; o = 7'b0010011; end
      2: begin c = INS_I; o = OP_LOAD; wl = 3'(1 << $urandom_range(0, 2)); end
      3: begin c = INS_S; o = 7'b0100011; wl = 3'(1 << $urandom_range(0, 2)); end
      4: begin c = INS_B; o = 7'b1100011; end
      5: begin c = INS_U; o = 7'b0110111; end
      6: begin c = INS_U; o = OP_AUIPC; end
      7: begin c = INS_J; o = OP_JAL; end
      default: begin c = INS_I; o = OP_JALR; end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    instype_t c;
    logic [6:0] o;
    logic [2:0] wl;
    do_reset();
    go_idle(2);

    // ADDI x1
    do_instr(INS_I, 7'b0010011, 5'd1, 3'd0, 0, 0, 0, 1, 0, lat);
    chk("addi_latency", 64'(lat), 64'd4);
    chk("addi_wb_fields", {last_wb.rf_we, last_wb.wb_sel, last_wb.pc_sel, last_wb.alu_b_imm}, 64'b1_00_00_1);
    chk("addi_instret", 64'(instret), 64'd1);
    // LW x2, 3 wait cycles in MEM
    do_instr(INS_I, OP_LOAD, 5'd2, 3'd4, 0, 0, 3, 1, 0, lat);
    chk("lw_latency", 64'(lat), 64'd8);
    chk("lw_wb_fields", {last_wb.rf_we, last_wb.wb_sel}, 64'b1_01);
    chk("lw_instret", 64'(instret), 64'd2);
    do_instr(INS_S, 7'b0100011, 5'd0, 3'd2, 0, 0, 0, 1, 0, lat);
    chk("sw_latency", 64'(lat), 64'd5);
    do_instr(INS_B, 7'b1100011, 5'd3, 3'd0, 1, 0, 0, 1, 0, lat);
    chk("beq_taken", {last_wb.pc_sel, last_wb.rf_we}, 64'b01_0);
    do_instr(INS_B, 7'b1100011, 5'd3, 3'd0, 0, 1, 0, 1, 0, lat);
    chk("beq_not_taken", 64'(last_wb.pc_sel), 64'd0);
    do_instr(INS_I, OP_JALR, 5'd1, 3'd0, 0, 0, 0, 1, 0, lat);
    chk("jalr_sels", {last_wb.pc_sel, last_wb.wb_sel}, 64'b10_10);
    do_instr(INS_J, OP_JAL, 5'd0, 3'd0, 0, 0, 0, 0, 0, lat);
    go_idle(3);
    // ready on the last permitted cycle must not trap
    do_instr(INS_I, OP_LOAD, 5'd4, 3'd1, 0, TMO - 1, TMO - 1, 0, 0, lat);
    chk("tmo_edge_no_trap", 64'(trap), 64'd0);
    go_idle(1);

    for (int n = 0; n < 200; n++) begin
      logic ra = ($urandom_range(0, 4) != 0);
      pick(c, o, wl);
      do_instr(c, o, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), wl, 1'($urandom),
               ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 2)),
               ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3)), ra, 0, lat);
      if (!ra) go_idle($urandom_range(0, 2));
    end
    do_instr(INS_R, 7'b0110011, 5'd5, 3'd0, 0, 0, 0, 0, 0, lat);

    // instret wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    go_idle(1);
    do_instr(INS_U, OP_AUIPC, 5'd6, 3'd0, 0, 0, 0, 0, 0, lat);
    chk("instret_wrap", 64'(instret), 64'd0);
    go_idle(1);

    // illegal instruction
    do_instr(INS_INVALID, 7'h7F, 5'd31, 3'd7, 0, 0, 0, 1, 0, lat);
    trap_cycles(1);
    chk("illegal_cause", {trap, trap_cause}, 64'b1_01);
    trap_cycles(8);
    do_reset();
    go_idle(1);

    // store with bad width
    st_we_seen = 0;
    do_instr(INS_S, 7'b0100011, 5'd0, 3'd0, 0, 0, 0, 1, 0, lat);
    trap_cycles(4);
    chk("badlen_cause", 64'(trap_cause), 64'd2);
    chk("badlen_no_store", 64'(st_we_seen), 64'd0);
    do_reset();
    go_idle(0);

    // fetch timeout
    do_instr(INS_R, 7'b0110011, 5'd1, 3'd0, 0, TMO + 4, 0, 1, 0, lat);
    chk("fetch_tmo_cycles", 64'(lat), 64'(TMO));
    trap_cycles(3);
    chk("fetch_tmo_cause", 64'(trap_cause), 64'd3);
    do_reset();
    go_idle(0);

    // mem timeout
    do_instr(INS_S, 7'b0100011, 5'd0, 3'd4, 0, 0, TMO + 2, 1, 0, lat);
    trap_cycles(3);
    chk("mem_tmo_cause", 64'(trap_cause), 64'd3);
    do_reset();
    go_idle(0);

    // reset mid-MEM
    do_instr(INS_I, OP_LOAD, 5'd7, 3'd2, 0, 0, 10, 1, 1, lat);
    do_reset();
    go_idle(0);
    do_instr(INS_I, 7'b0010011, 5'd1, 3'd0, 0, 0, 0, 0, 0, lat);
    chk("restart_instret", 64'(instret), 64'd1);
    go_idle(0);

    exp_v = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
